// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer.
//   state_t       - sequencer states (IDLE, LOAD, SHIFT, DONE)
//   DEFAULT_WIDTH - default width of the driven load/shift register
//   calc_cw()     - width of a count field able to hold 0..width
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The count must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_sequencer_counter.sv
// Loadable down-counter for the remaining shift count.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset (count -> 0)
//   load       in   load load_value (has priority over en)
//   load_value in   CW  value to load
//   en         in   decrement by one
//   count      out  CW  current count
//   zero       out  count == 0
//   is_one     out  count == 1
module shift_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          zero,
  output logic          is_one
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign count  = count_reg;
  assign zero   = (count_reg == '0);
  assign is_one = (count_reg == CW'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Control stage driving an external load/shift register: on a start request
// it issues one load cycle followed by exactly min(shamt, WIDTH) shift
// cycles (paused by hold) and then a one-cycle done pulse.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   start     in   request strobe, honoured only in IDLE
//   data_in   in   WIDTH value to load
//   shamt     in   CW    requested number of right shifts
//   arith     in   1 = arithmetic (MSB fill), 0 = logical
//   hold      in   pause shifting while high
//   load_val  out  WIDTH captured data_in for the register's parallel inputs
//   load_n    out  active-low load command
//   shift     out  shift-enable command
//   asr       out  captured arith (MSB-fill select)
//   busy      out  sequence in progress (LOAD .. DONE)
//   done      out  one-cycle completion pulse
// All outputs are registered.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CW-1:0]    shamt,
  input  logic             arith,
  input  logic             hold,
  output logic [WIDTH-1:0] load_val,
  output logic             load_n,
  output logic             shift,
  output logic             asr,
  output logic             busy,
  output logic             done
);

  state_t state_reg, state_next;

  logic [WIDTH-1:0] load_val_reg;
  logic             load_n_reg;
  logic             shift_reg;
  logic             asr_reg;
  logic             busy_reg;
  logic             done_reg;

  logic          cnt_load;
  logic          cnt_en;
  logic [CW-1:0] cnt_value;
  logic          cnt_zero;
  logic          cnt_is_one;
  logic [CW-1:0] shamt_clamped;

  assign shamt_clamped = (shamt > CW'(WIDTH)) ? CW'(WIDTH) : shamt;

  shift_counter #(
    .CW(CW)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (shamt_clamped),
    .en         (cnt_en),
    .count      (cnt_value),
    .zero       (cnt_zero),
    .is_one     (cnt_is_one)
  );

  // Next-state logic. Because shift is registered, a cycle in SHIFT counts
  // as a real shift only when shift_reg is high; that is the cycle in which
  // the count is consumed.
  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          cnt_load   = 1'b1;
        end
      end
      LOAD: begin
        state_next = cnt_zero ? DONE : SHIFT;
      end
      SHIFT: begin
        if (shift_reg) begin
          cnt_en = 1'b1;
          if (cnt_is_one) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe while staying fully registered. hold is sampled at the
  // edge, so it gates the following cycle's shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      load_val_reg <= '0;
      asr_reg      <= 1'b0;
      load_n_reg   <= 1'b1;
      shift_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (cnt_load) begin
        load_val_reg <= data_in;
        asr_reg      <= arith;
      end
      load_n_reg <= (state_next != LOAD);
      shift_reg  <= (state_next == SHIFT) && !hold;
      busy_reg   <= (state_next != IDLE);
      done_reg   <= (state_next == DONE);
    end
  end

  assign load_val = load_val_reg;
  assign load_n   = load_n_reg;
  assign shift    = shift_reg;
  assign asr      = asr_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer with a behavioural model of the
// downstream 8-bit load/shift register.
module tb_shift_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] shamt;
  logic       arith;
  logic       hold;
  logic [7:0] load_val;
  logic       load_n;
  logic       shift;
  logic       asr;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] dreg;

  shift_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .shamt    (shamt),
    .arith    (arith),
    .hold     (hold),
    .load_val (load_val),
    .load_n   (load_n),
    .shift    (shift),
    .asr      (asr),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream register driven by the sequencer's commands.
  always @(posedge clk) begin
    if (!load_n) dreg <= load_val;
    else if (shift) dreg <= {asr & dreg[7], dreg[7:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One request; cycle k = k-th cycle after the accepting edge.
  task automatic run_seq(input string tag, input logic [7:0] d, input logic [3:0] sh,
                         input logic ar, input int hold_from, input int hold_len,
                         input int poke_at, input int exp_shifts, input int exp_done,
                         input logic [7:0] exp_reg);
    int loads, shifts, done_at, busy_bad, overlap, lv_bad, asr_bad;
    loads = 0; shifts = 0; done_at = -1; busy_bad = 0; overlap = 0; lv_bad = 0; asr_bad = 0;
    @(negedge clk);
    data_in = d; shamt = sh; arith = ar; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; data_in = 8'h5A; shamt = 4'd7; arith = ~ar;
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      @(negedge clk);
      hold  = (k >= hold_from) && (k < hold_from + hold_len);
      start = (k == poke_at);
      if (!load_n) loads++;
      if (shift) shifts++;
      if (!load_n && shift) overlap++;
      if (!busy) busy_bad++;
      if (load_val !== d) lv_bad++;
      if (asr !== ar) asr_bad++;
      if (done) done_at = k;
    end
    start = 1'b0; hold = 1'b0;
    @(negedge clk);
    check({tag, "_loads"}, loads, 1);
    check({tag, "_shifts"}, shifts, exp_shifts);
    check({tag, "_done_at"}, done_at, exp_done);
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_busy_gap"}, busy_bad, 0);
    check({tag, "_load_val"}, lv_bad, 0);
    check({tag, "_asr"}, asr_bad, 0);
    check({tag, "_reg"}, dreg, exp_reg);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    $display("[TB] %s: data=%h shamt=%0d arith=%0d shifts=%0d done_at=%0d reg=%h",
             tag, d, sh, ar, shifts, done_at, dreg);
  endtask

  initial begin
    int load_first, load_second, done_cnt, busy_cnt;
    reset = 1'b1; start = 1'b0; data_in = '0; shamt = '0; arith = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_load_val", load_val, 0);
    check("rst_load_n", load_n, 1);
    check("rst_shift", shift, 0);
    check("rst_asr", asr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    $display("[TB] reset: load_val=%h load_n=%0d shift=%0d busy=%0d", load_val, load_n, shift, busy);

    run_seq("logical", 8'hB4, 4'd3, 1'b0, 99, 0, -1, 3, 5, 8'h16);
    run_seq("arith", 8'h96, 4'd2, 1'b1, 99, 0, -1, 2, 4, 8'hE5);
    run_seq("shamt0", 8'hA5, 4'd0, 1'b0, 99, 0, -1, 0, 2, 8'hA5);
    run_seq("shamt12", 8'hFF, 4'd12, 1'b0, 99, 0, -1, 8, 10, 8'h00);
    run_seq("shamt12_asr", 8'h80, 4'd12, 1'b1, 99, 0, -1, 8, 10, 8'hFF);
    run_seq("hold_poke", 8'hC3, 4'd4, 1'b0, 2, 2, 4, 4, 8, 8'h0C);

    // Reset mid-SHIFT after two shifts: no done pulse, outputs to reset values.
    @(negedge clk);
    data_in = 8'hF0; shamt = 4'd5; arith = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 3) reset = 1'b1;
      if (k == 5) reset = 1'b0;
      if (k == 4) begin
        check("midrst_load_val", load_val, 0);
        check("midrst_load_n", load_n, 1);
        check("midrst_shift", shift, 0);
        check("midrst_asr", asr, 0);
        check("midrst_busy", busy, 0);
      end
      if (k >= 4 && done) done_cnt++;
      if (k >= 4 && busy) busy_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_stay_idle", busy_cnt, 0);
    $display("[TB] mid-shift reset: done pulses=%0d busy cycles=%0d", done_cnt, busy_cnt);

    // Back-to-back with start held high: n=1, loads at t+1 and t+5.
    @(negedge clk);
    data_in = 8'h81; shamt = 4'd1; arith = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 data_in = 8'h3C;
    load_first = -1; load_second = -1; busy_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!load_n) begin
        if (load_first < 0) load_first = k;
        else if (load_second < 0) load_second = k;
      end
      if (k == 4) begin
        check("b2b_idle_busy", busy, 0);
        check("b2b_hold_val", load_val, 8'h81);
      end
      if (k == 5) begin
        start = 1'b0;
        check("b2b_new_val", load_val, 8'h3C);
      end
      if (k >= 9 && busy) busy_cnt++;
    end
    check("b2b_load1", load_first, 1);
    check("b2b_load2", load_second, 5);
    check("b2b_back_idle", busy_cnt, 0);
    $display("[TB] back-to-back: loads at %0d and %0d", load_first, load_second);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
